fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Upstream master of the 16-bit processor's single-port memory. Owns the PC,
//  fetches instruction words into a small prefetch queue for decode, and shares
//  the memory port with load/store requests from execute.
//  Memory read is combinational: data on mem_rdata is valid in the same cycle
//  as mem_addr/mem_rd. At most one memory access happens per cycle.
// PARAMETERS
//  AW        8   address width; PC and all addresses are AW bits
//  DW        16  data/instruction width
//  QDEPTH    2   prefetch queue entries; power of 2, >= 2
//  RESET_PC  0   PC value after reset
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  en           in   1   fetch enable
//  redirect     in   1   branch/jump taken: flush queue, load redirect_pc
//  redirect_pc  in   AW  new PC
//  ls_req       in   1   load/store request; held until ls_done
//  ls_we        in   1   1 = store, 0 = load; stable while ls_req is high
//  ls_addr      in   AW  load/store address; stable while ls_req is high
//  ls_wdata     in   DW  store data; stable while ls_req is high
//  ls_rdata     out  DW  load data; registered; valid when ls_done=1
//  ls_done      out  1   one-cycle completion pulse
//  ins_valid    out  1   queue head valid
//  ins_data     out  DW  queue head instruction
//  ins_pc       out  AW  address the head instruction was fetched from
//  ins_ready    in   1   decode accepts head (pop when ins_valid & ins_ready)
//  mem_addr     out  AW  memory address
//  mem_rd       out  1   memory read strobe
//  mem_wr       out  1   memory write strobe
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data; combinational from memory
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, state=IDLE, ls_rdata=0, ls_done=0.
//   In IDLE: ins_valid=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
//  FSM:
//   IDLE: go to FETCH when en=1.
//   FETCH: if ls_req=1, grant load/store this cycle, then go to LSDONE.
//   LSDONE: ls_done=1 for this cycle. No new load/store grant in this state;
//    fetch is allowed. Return to FETCH.
//  Load/store grant (combinational, same cycle):
//   mem_addr=ls_addr; mem_wr=ls_we; mem_rd=~ls_we; mem_wdata=ls_wdata.
//   For a load, ls_rdata<=mem_rdata at the edge.
//   No fetch in a grant cycle. Load/store latency is 2 cycles (req to done).
//  Fetch cycle:
//   Conditions: state is FETCH or LSDONE, no grant, en=1, redirect=0,
//    queue not full.
//   Action: mem_rd=1, mem_addr=pc. At the edge, push {pc, mem_rdata} and set
//    pc <= pc+1, wrapping modulo 2^AW (pc = 2^AW-1 is followed by 0).
//  mem_rd and mem_wr are never high together.
//   Both are 0 when no access happens in a cycle.
//  Queue: FIFO in fetch order.
//   ins_valid = not empty; ins_data/ins_pc show the head.
//   A push and a pop in the same cycle leave the count unchanged.
//   A full queue blocks fetch even if a pop happens that cycle.
//  redirect=1 (any non-IDLE state; priority over fetch and pop):
//   At the edge, empty the queue and set pc <= redirect_pc.
//   No fetch happens that cycle. An in-flight load/store grant still completes.
//   ins_valid=0 in the following cycle.
//  en=0: fetch is suppressed. The queue still drains and loads/stores are
//   still served. State does not return to IDLE.
//  Async reset mid-operation: all state returns to reset values immediately,
//   and mem_wr/mem_rd drop the same instant. An interrupted load/store never
//   gets ls_done.
// TESTING
//  1 mem[0..3]=A,B,C,D, ins_ready=1, en=1 from cycle 0 -> first mem_rd/addr 0
//    in cycle 1; ins_valid in cycle 2 with ins_pc=0, data=A; then B,C,D on
//    consecutive cycles.
//  2 ins_ready=0 -> exactly 2 entries queued (pc 0,1), mem_rd=0, pc holds at 2;
//    release -> ins_pc 0,1,2 in order, no gaps or duplicates.
//  3 store ls_addr=0x80, ls_wdata=0x1234 -> one cycle mem_wr=1, addr=0x80,
//    mem_rd=0; ls_done next cycle. Then a load from 0x80 -> ls_rdata=0x1234
//    with ls_done.
//  4 Full queue + redirect to 0x40 -> next cycle ins_valid=0; next mem_addr is
//    0x40; first delivered ins_pc=0x40.
//  5 redirect to 0xFF -> delivered ins_pc 0xFF then 0x00.
//  6 rst_n low during a store grant -> mem_wr=0 immediately; after release:
//    IDLE, ins_valid=0, ls_done never pulses, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC owner and instruction prefetcher sharing one memory port with
//            load/store traffic from execute.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int QDEPTH   = 2,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    output logic          ins_valid,
    output logic [DW-1:0] ins_data,
    output logic [AW-1:0] ins_pc,
    input  logic          ins_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            PW         = $clog2(QDEPTH);
    localparam logic [AW-1:0] C_RESET_PC = AW'(RESET_PC);
    localparam logic [PW:0]   C_QDEPTH   = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_LSDONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_pc;
    logic [DW-1:0]   r_ls_rdata;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [DW-1:0]   r_q_data [QDEPTH];
    logic [AW-1:0]   r_q_pc   [QDEPTH];

    logic            w_active;
    logic            w_grant;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic            w_fetch;
    logic            w_pop;

    assign w_active = (r_state != S_IDLE);
    assign w_grant  = (r_state == S_FETCH) && ls_req;
    assign w_flush  = w_active && redirect;
    assign w_full   = (r_count == C_QDEPTH);
    assign w_empty  = (r_count == '0);
    // Full blocks fetch even when a pop is pending: no push/pop bypass path.
    assign w_fetch  = w_active && !w_grant && en && !redirect && !w_full;
    assign w_pop    = !w_empty && ins_ready && !w_flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (en) w_state_nxt = S_FETCH;
            S_FETCH:  if (w_grant) w_state_nxt = S_LSDONE;
            S_LSDONE: w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        if (w_grant) begin
            mem_addr  = ls_addr;
            mem_wr    = ls_we;
            mem_rd    = ~ls_we;
            mem_wdata = ls_wdata;
        end else if (w_fetch) begin
            mem_addr  = r_pc;
            mem_rd    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= C_RESET_PC;
            r_ls_rdata <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant && !ls_we)
                r_ls_rdata <= mem_rdata;
            if (w_flush) begin
                r_pc     <= redirect_pc;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_fetch) begin
                    r_pc     <= r_pc + AW'(1);
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                if (w_fetch && !w_pop)
                    r_count <= r_count + (PW+1)'(1);
                else if (!w_fetch && w_pop)
                    r_count <= r_count - (PW+1)'(1);
            end
        end
    end

    // Queue payload needs no reset; validity is carried by r_count.
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_q_data[r_wr_ptr] <= mem_rdata;
            r_q_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign ls_rdata  = r_ls_rdata;
    assign ls_done   = (r_state == S_LSDONE);
    assign ins_valid = !w_empty;
    assign ins_data  = r_q_data[r_rd_ptr];
    assign ins_pc    = r_q_pc[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a memory model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] ls_rdata;
    logic          ls_done;
    logic          ins_valid;
    logic [DW-1:0] ins_data;
    logic [AW-1:0] ins_pc;
    logic          ins_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [256];

    int n_tests;
    int n_fail;

    fetch_unit #(.AW(AW), .DW(DW), .QDEPTH(2), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_rdata    (ls_rdata),
        .ls_done     (ls_done),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        ins_ready = 1'b0;
        repeat (2) @(posedge clk);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[8'h00] = 16'hAAAA;
        mem[8'h01] = 16'hBBBB;
        mem[8'h02] = 16'hCCCC;
        mem[8'h03] = 16'hDDDD;
        mem[8'h40] = 16'h4040;
        mem[8'hFF] = 16'hF0FF;

        // ---- Reset state and straight-line fetch
        do_reset();
        #1;
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_mem_rd",    32'(mem_rd),    32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_ls_done",   32'(ls_done),   32'd0);
        check("rst_ls_rdata",  32'(ls_rdata),  32'd0);
        en = 1'b1; ins_ready = 1'b1;
        #1 check("c0_mem_rd", 32'(mem_rd), 32'd0);
        step(); #1;
        check("c1_mem_rd",    32'(mem_rd),    32'd1);
        check("c1_mem_addr",  32'(mem_addr),  32'd0);
        check("c1_ins_valid", 32'(ins_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            check("seq_valid", 32'(ins_valid), 32'd1);
            check("seq_pc",    32'(ins_pc),    32'(k));
            check("seq_data",  32'(ins_data),  32'(k == 0 ? 16'hAAAA : k == 1 ? 16'hBBBB :
                                                  k == 2 ? 16'hCCCC : 16'hDDDD));
        end

        // ---- Back-pressure: queue fills with pc 0,1 and fetch stops
        do_reset();
        en = 1'b1; ins_ready = 1'b0;
        step(); step(); step(); #1;
        check("bp_mem_rd", 32'(mem_rd), 32'd0);
        check("bp_pc0",    32'(ins_pc), 32'd0);
        step(); ins_ready = 1'b1; #1;
        check("bp_full_pop_no_fetch", 32'(mem_rd), 32'd0);
        check("bp_head0", 32'(ins_pc), 32'd0);
        step(); #1;
        check("bp_head1", 32'(ins_pc),   32'd1);
        check("bp_fetch2_rd", 32'(mem_rd), 32'd1);
        check("bp_fetch2_addr", 32'(mem_addr), 32'd2);
        step(); #1;
        check("bp_head2", 32'(ins_pc), 32'd2);

        // ---- Store then load through the shared port
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h80; ls_wdata = 16'h1234; #1;
        check("st_mem_wr",    32'(mem_wr),    32'd1);
        check("st_mem_rd",    32'(mem_rd),    32'd0);
        check("st_mem_addr",  32'(mem_addr),  32'h80);
        check("st_mem_wdata", 32'(mem_wdata), 32'h1234);
        check("st_no_done",   32'(ls_done),   32'd0);
        step(); #1;
        check("st_done",       32'(ls_done),  32'd1);
        check("st_done_no_wr", 32'(mem_wr),   32'd0);
        check("lsdone_fetch",  32'(mem_addr), 32'd3);
        ls_we = 1'b0;
        step(); #1;
        check("ld_mem_rd",   32'(mem_rd),   32'd1);
        check("ld_mem_wr",   32'(mem_wr),   32'd0);
        check("ld_mem_addr", 32'(mem_addr), 32'h80);
        step(); #1;
        check("ld_done",   32'(ls_done),  32'd1);
        check("ld_rdata",  32'(ls_rdata), 32'h1234);
        ls_req = 1'b0;

        // ---- Redirect from a full queue
        ins_ready = 1'b0;
        step(); step(); #1;
        check("rd_full_rd",    32'(mem_rd),    32'd0);
        check("rd_full_valid", 32'(ins_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 8'h40;
        step(); redirect = 1'b0; #1;
        check("rd_flush_valid", 32'(ins_valid), 32'd0);
        check("rd_new_rd",      32'(mem_rd),    32'd1);
        check("rd_new_addr",    32'(mem_addr),  32'h40);
        step(); #1;
        check("rd_first_pc",   32'(ins_pc),   32'h40);
        check("rd_first_data", 32'(ins_data), 32'h4040);
        ins_ready = 1'b1;

        // ---- PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 8'hFF;
        step(); redirect = 1'b0; #1;
        check("wr_addr_ff", 32'(mem_addr), 32'hFF);
        check("wr_valid0",  32'(ins_valid), 32'd0);
        step(); #1;
        check("wr_pc_ff",   32'(ins_pc),   32'hFF);
        check("wr_data_ff", 32'(ins_data), 32'hF0FF);
        step(); #1;
        check("wr_pc_00",   32'(ins_pc),   32'h00);
        check("wr_data_00", 32'(ins_data), 32'hAAAA);

        // ---- Asynchronous reset in the middle of a store grant
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h90; ls_wdata = 16'hBEEF; #1;
        check("ar_pre_wr", 32'(mem_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_wr_drop", 32'(mem_wr), 32'd0);
        check("ar_rd_drop", 32'(mem_rd), 32'd0);
        check("ar_valid",   32'(ins_valid), 32'd0);
        ls_req = 1'b0; en = 1'b0;
        repeat (2) @(posedge clk);
        step(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ar_no_done",  32'(ls_done),   32'd0);
            check("ar_idle_rd",  32'(mem_rd),    32'd0);
            check("ar_idle_val", 32'(ins_valid), 32'd0);
            step();
        end
        check("ar_mem_untouched", 32'(mem[8'h90]), 32'h1090);
        en = 1'b1;
        step(); #1;
        check("ar_pc_reset_rd",   32'(mem_rd),   32'd1);
        check("ar_pc_reset_addr", 32'(mem_addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
